// File: rtl/data_in_packer_if.sv
// Beat-in / word-out handshake bundle for the data_in_packer.
// The packer takes the slave side; whatever feeds it and drains it takes the master side.
interface data_in_packer_if #(
  parameter int IN_W  = 8,
  parameter int LANES = 4
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_mode;
  logic [LANE_W-1:0]     in_lane;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_W*LANES-1:0] out_data;
  logic [LANES-1:0]      out_keep;

  modport master (
    output in_valid, in_data, in_mode, in_lane, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_lane, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );
endinterface

// File: rtl/data_in_packer.sv
// Packs narrow input beats into LANES-wide output words, either by auto-incrementing
// lanes (order set by ORDER) or by direct lane addressing, with partial-word flush.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | output register holds no unconsumed word, out_valid=0
// ST_FULL  | completed word waiting in output register, out_valid=1
module data_in_packer #(
  parameter int IN_W  = 8,
  parameter int LANES = 4,
  parameter int ORDER = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_in_packer_if.slave        bus,
  output logic                   busy
);

  localparam int OUT_W  = IN_W * LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_CNT = LANE_W'(LANES - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [OUT_W-1:0]  asm_data_q;
  logic [LANES-1:0]  asm_keep_q;
  logic [LANE_W-1:0] count_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [LANES-1:0]  out_keep_q;

  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              auto_beat;
  logic              complete;
  logic [LANE_W-1:0] lane_sel;
  logic [OUT_W-1:0]  merged_data;
  logic [LANES-1:0]  merged_keep;

  assign accept    = bus.in_valid && in_ready;
  assign auto_beat = !bus.in_mode;
  assign complete  = accept && ((auto_beat && (count_q == LAST_CNT)) || bus.in_last);

  // Direct lanes are physical; ORDER only remaps the auto-increment sequence.
  always_comb begin
    lane_sel = count_q;
    if (bus.in_mode) begin
      lane_sel = bus.in_lane;
    end else if (ORDER != 0) begin
      lane_sel = LAST_CNT - count_q;
    end
  end

  // An out-of-range direct lane (non power-of-two LANES) matches nothing and is dropped.
  always_comb begin
    merged_data = asm_data_q;
    merged_keep = asm_keep_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_sel == LANE_W'(k)) begin
        merged_data[IN_W*k +: IN_W] = bus.in_data;
        merged_keep[k]              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A completing beat refills the output register on the same edge it drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (complete) begin
          state_d = ST_FULL;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    in_ready  = !out_valid || bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_data_q <= '0;
      asm_keep_q <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      out_keep_q <= '0;
    end else if (accept) begin
      if (complete) begin
        out_data_q <= merged_data;
        out_keep_q <= merged_keep;
        asm_data_q <= '0;
        asm_keep_q <= '0;
        count_q    <= '0;
      end else begin
        asm_data_q <= merged_data;
        asm_keep_q <= merged_keep;
        if (auto_beat) begin
          count_q <= count_q + LANE_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign busy          = |asm_keep_q;

endmodule

// File: doc/data_in_packer.md
Name: data_in_packer

Overview:
- Parametrised successor to the fixed 8-to-32 byte-lane loader.
- Packs a stream of narrow input beats into wide output words, with valid/ready handshakes on both sides.
- Two lane-selection modes: auto-increment packing with a selectable lane order, or direct-addressed lane writes.
- Supports partial-word flush with per-lane keep flags. Sits between the narrow host/IO data path and wide user-project registers.

Parameters:
- IN_W, 8, input beat width in bits (≥1).
- LANES, 4, beats per output word (≥2); output width is IN_W*LANES.
- ORDER, 0, auto-mode lane order. 0 = first beat to lane 0 (LSBs). 1 = first beat to lane LANES-1 (MSBs).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_W  input beat.
- in_mode  in  1  0 = auto-increment, 1 = direct lane write; sampled per beat.
- in_lane  in  clog2(LANES)  target lane in direct mode; ignored in auto mode.
- in_last  in  1  beat closes the current word (flush or commit).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  IN_W*LANES  packed word; lane k = bits [IN_W*k +: IN_W].
- out_keep  out  LANES  bit k set = lane k was written in this word.
- busy  out  1  partial word held in the assembly register.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_keep=0.
  - Assembly data=0, assembly keep=0, lane count=0, busy=0.
  - Reset mid-word discards the partial word and any unaccepted output word.
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output word transferred when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Beats stall only while a completed word is blocked.
  - out_data and out_keep stay stable while out_valid && !out_ready.
- Lane selection for an accepted beat:
  - Auto mode: lane = count (ORDER=0) or LANES-1-count (ORDER=1).
  - Direct mode: lane = in_lane, always physical; ORDER does not apply.
- Beat write:
  - in_data goes into the assembly lane and sets that lane's keep bit.
  - Rewriting a lane already written in the same word overwrites it; keep stays 1.
- Count:
  - Increments only on auto-mode beats.
  - Mixing modes within one word is legal; count only tracks auto beats.
- Word completion (on the accepted beat) occurs on either of:
  - an auto beat with count==LANES-1;
  - any beat with in_last=1.
- On completion, at the next edge:
  - out_data = assembly data merged with the current beat; unwritten lanes are 0.
  - out_keep = assembly keep merged with the current lane bit.
  - out_valid=1.
  - Assembly data, keep and count clear to 0.
- Latency: one cycle from the completing beat to out_valid.
- Throughput: one word per LANES cycles sustained. The output register refills on the same edge it drains, with no bubble.
- Non-completing beats only update assembly state. They are accepted even while out_valid=1 as long as in_ready=1.
- out_valid clears after a transfer unless a new word completes on that same edge.
- busy = (assembly keep != 0). busy is 0 immediately after completion.
- in_last on the first beat of a word emits a single-lane word.

Test Plan:
- Auto pack, defaults, ORDER=0: beats 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one cycle after the 4th beat, out_data=0x44332211, out_keep=4'b1111, out_valid high for one cycle; busy 1,1,1,0.
- ORDER=1 instance: same beats -> out_data=0x11223344, keep=4'b1111.
- Partial flush: auto beats 0xAA, then 0xBB with in_last=1 -> out_data=0x0000BBAA, out_keep=4'b0011, count back to 0; next beat 0xCC lands in lane 0.
- Direct mode:
  - in_lane=2 data 0x5A, then in_lane=0 data 0xC3, then in_lane=2 data 0x7E with in_last=1 -> out_data=0x007E00C3, out_keep=4'b0101.
- Backpressure:
  - Hold out_ready=0 after a word completes; in_ready=0 while the next word's 4th beat is presented.
  - First word stays stable on out_data.
  - Raise out_ready -> first word transfers, 4th beat accepted that cycle, second word valid next cycle; no beat lost or duplicated.
- Reset mid-operation: 2 auto beats accepted, pulse rst_n low asynchronously between edges -> out_valid, out_data, out_keep and busy drop to 0 immediately; next 4 beats 0x01..0x04 give 0x04030201.
